dma_spi_master: RTL and testbench

- Byte-wide SPI mode-0 master that sits directly downstream of the DMA engine's SPI device port. It services DMA byte requests (spi_req/spi_stb handshake) and direct Z80 data/config port accesses.
- Drives the SD-card SPI pins.
- The DMA assembles 16-bit words from two consecutive byte strobes, so this block guarantees exactly one strobe per shifted byte.

---
 rtl/dma_spi_master.sv | 207 ++++++++++++++++++++
 tb/tb_dma_spi_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_spi_master.sv
// Byte-wide SPI mode-0 master serving DMA byte requests and Z80 data/config port accesses.
// Optional build macro SPI_LSBF_EN adds an LSB-first mode selected by config bit 1.
module dma_spi_master #(
    parameter int unsigned DIV    = 1,
    parameter logic        CS_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] zdata,
    input  logic       z_dwr,
    input  logic       z_drd,
    input  logic       z_cfgwr,
    output logic [7:0] z_rddata,
    output logic       z_busy,
    input  logic       spi_req,
    input  logic [7:0] spi_wrdata,
    output logic [7:0] spi_rddata,
    output logic       spi_stb,
    output logic       sd_clk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_cs_n
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] div_q, div_d;
    logic       clk_q, clk_d;
    logic       mosi_q, mosi_d;
    logic       miso_q;
    logic       sample_q, sample_d;
    logic       owner_q, owner_d;
    logic       pend_q, pend_d;
    logic [7:0] pendData_q, pendData_d;
    logic [7:0] zrd_q, zrd_d;
    logic [7:0] srd_q, srd_d;
    logic       cs_q, cs_d;

    logic       zStart;
    logic [7:0] zByte;
    logic       startEn;
    logic [7:0] startByte;
    logic       startOwner;
    logic       startLsbf;
    logic       curLsbf;

    assign zStart = z_dwr | z_drd;
    assign zByte  = z_dwr ? zdata : 8'hFF;

`ifdef SPI_LSBF_EN
    logic lsbf_q;
    logic xferLsbf_q;

    // Bit order is frozen per byte so a config write mid-byte only affects the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsbf_q     <= 1'b0;
            xferLsbf_q <= 1'b0;
        end else begin
            if (z_cfgwr) lsbf_q <= zdata[1];
            if (startEn) xferLsbf_q <= lsbf_q;
        end
    end

    assign startLsbf = lsbf_q;
    assign curLsbf   = xferLsbf_q;
`else
    assign startLsbf = 1'b0;
    assign curLsbf   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 8'hFF;
            rx_q       <= 8'hFF;
            cnt_q      <= 3'd0;
            div_q      <= 8'd0;
            clk_q      <= 1'b0;
            mosi_q     <= 1'b1;
            miso_q     <= 1'b1;
            sample_q   <= 1'b0;
            owner_q    <= 1'b0;
            pend_q     <= 1'b0;
            pendData_q <= 8'hFF;
            zrd_q      <= 8'hFF;
            srd_q      <= 8'hFF;
            cs_q       <= CS_RST;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            clk_q      <= clk_d;
            mosi_q     <= mosi_d;
            miso_q     <= sd_miso;
            sample_q   <= sample_d;
            owner_q    <= owner_d;
            pend_q     <= pend_d;
            pendData_q <= pendData_d;
            zrd_q      <= zrd_d;
            srd_q      <= srd_d;
            cs_q       <= cs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        clk_d      = clk_q;
        mosi_d     = mosi_q;
        sample_d   = 1'b0;
        owner_d    = owner_q;
        pend_d     = pend_q;
        pendData_d = pendData_q;
        zrd_d      = zrd_q;
        srd_d      = srd_q;
        cs_d       = cs_q;
        startEn    = 1'b0;
        startByte  = 8'hFF;
        startOwner = 1'b0;

        if (z_cfgwr) cs_d = zdata[0];

        // miso_q was captured on the same clk edge that raised sd_clk, so it is shifted in one cycle later.
        if (sample_q) rx_d = curLsbf ? {miso_q, rx_q[7:1]} : {rx_q[6:0], miso_q};

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    startEn   = 1'b1;
                    startByte = pendData_q;
                    pend_d    = 1'b0;
                end else if (zStart) begin
                    startEn   = 1'b1;
                    startByte = zByte;
                end else if (spi_req) begin
                    startEn    = 1'b1;
                    startByte  = spi_wrdata;
                    startOwner = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == 8'd0) begin
                    div_d = DIV_M1;
                    clk_d = ~clk_q;
                    if (!clk_q) begin
                        sample_d = 1'b1;
                    end else begin
                        tx_d   = curLsbf ? {1'b1, tx_q[7:1]} : {tx_q[6:0], 1'b1};
                        mosi_d = curLsbf ? tx_q[1] : tx_q[6];
                        if (cnt_q == 3'd7) begin
                            state_d = DONE;
                            zrd_d   = rx_d;
                            srd_d   = rx_d;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A Z80 access that arrives mid-transfer waits in a one-deep slot; extra pulses are dropped.
        if (state_q != IDLE && zStart && !pend_q) begin
            pend_d     = 1'b1;
            pendData_d = zByte;
        end

        if (startEn) begin
            state_d = SHIFT;
            tx_d    = startByte;
            owner_d = startOwner;
            cnt_d   = 3'd0;
            div_d   = DIV_M1;
            clk_d   = 1'b0;
            mosi_d  = startLsbf ? startByte[0] : startByte[7];
        end
    end

    assign sd_clk     = clk_q;
    assign sd_mosi    = mosi_q;
    assign sd_cs_n    = cs_q;
    assign z_rddata   = zrd_q;
    assign spi_rddata = srd_q;
    assign spi_stb    = (state_q == DONE) && owner_q;
    assign z_busy     = (state_q != IDLE) || pend_q || zStart;

endmodule

// File: tb/tb_dma_spi_master.sv
// Directed self-checking bench for dma_spi_master with sd_miso looped back to sd_mosi.
module tb_dma_spi_master;

    logic       clk;
    logic       rst_n;
    logic [7:0] zdata;
    logic       z_dwr;
    logic       z_drd;
    logic       z_cfgwr;
    logic [7:0] z_rddata;
    logic       z_busy;
    logic       spi_req;
    logic [7:0] spi_wrdata;
    logic [7:0] spi_rddata;
    logic       spi_stb;
    logic       sd_clk;
    logic       sd_mosi;
    logic       sd_miso;
    logic       sd_cs_n;

    int testsRun = 0;
    int failCnt  = 0;

    int          busyCnt;
    int          pulses;
    logic [15:0] mosiBits;
    int          stbCnt;
    int          stbCycle [4];
    logic [7:0]  stbData [4];
    logic        prevClk;
    logic        stbSeen;
    int          injectCycle;
    logic [7:0]  injectData;
    logic [7:0]  nextWr;
    int          dropAfter;

    dma_spi_master #(.DIV(1), .CS_RST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .zdata      (zdata),
        .z_dwr      (z_dwr),
        .z_drd      (z_drd),
        .z_cfgwr    (z_cfgwr),
        .z_rddata   (z_rddata),
        .z_busy     (z_busy),
        .spi_req    (spi_req),
        .spi_wrdata (spi_wrdata),
        .spi_rddata (spi_rddata),
        .spi_stb    (spi_stb),
        .sd_clk     (sd_clk),
        .sd_mosi    (sd_mosi),
        .sd_miso    (sd_miso),
        .sd_cs_n    (sd_cs_n)
    );

    assign sd_miso = sd_mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles from a post-edge point; cycle 0 inputs are set by the caller beforehand.
    task automatic applyStimulus(input int n);
        busyCnt  = 0;
        pulses   = 0;
        mosiBits = 16'h0000;
        stbCnt   = 0;
        prevClk  = sd_clk;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (z_busy) busyCnt++;
            if (sd_clk && !prevClk) begin
                if (pulses < 16) mosiBits = {mosiBits[14:0], sd_mosi};
                pulses++;
            end
            prevClk = sd_clk;
            stbSeen = spi_stb;
            if (spi_stb) begin
                if (stbCnt < 4) begin
                    stbCycle[stbCnt] = i;
                    stbData[stbCnt]  = spi_rddata;
                end
                stbCnt++;
            end
            tick();
            z_dwr = 1'b0;
            z_drd = 1'b0;
            if (i + 1 == injectCycle) begin
                z_dwr = 1'b1;
                zdata = injectData;
            end
            if (stbSeen) begin
                if (stbCnt == 1) spi_wrdata = nextWr;
                if (stbCnt == dropAfter) spi_req = 1'b0;
            end
        end
        injectCycle = -1;
    endtask

    task automatic cfgWrite(input logic [7:0] value);
        zdata   = value;
        z_cfgwr = 1'b1;
        tick();
        z_cfgwr = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        zdata       = 8'h00;
        z_dwr       = 1'b0;
        z_drd       = 1'b0;
        z_cfgwr     = 1'b0;
        spi_req     = 1'b0;
        spi_wrdata  = 8'hFF;
        injectCycle = -1;
        injectData  = 8'h00;
        nextWr      = 8'hFF;
        dropAfter   = 0;

        tick();
        tick();
        checkOutput("rst_sd_clk", {31'd0, sd_clk}, 32'd0);
        checkOutput("rst_sd_mosi", {31'd0, sd_mosi}, 32'd1);
        checkOutput("rst_sd_cs_n", {31'd0, sd_cs_n}, 32'd1);
        checkOutput("rst_spi_stb", {31'd0, spi_stb}, 32'd0);
        checkOutput("rst_z_busy", {31'd0, z_busy}, 32'd0);
        checkOutput("rst_z_rddata", {24'd0, z_rddata}, 32'hFF);
        checkOutput("rst_spi_rddata", {24'd0, spi_rddata}, 32'hFF);
        rst_n = 1'b1;
        tick();

        $display("[TB] Z80 write 0xA5");
        zdata = 8'hA5;
        z_dwr = 1'b1;
        applyStimulus(25);
        checkOutput("wr_pulses", pulses, 8);
        checkOutput("wr_mosi_seq", {16'd0, mosiBits}, 32'h00A5);
        checkOutput("wr_busy_cycles", busyCnt, 18);
        checkOutput("wr_z_rddata", {24'd0, z_rddata}, 32'hA5);
        checkOutput("wr_no_stb", stbCnt, 0);

        $display("[TB] reset in the middle of a DMA byte");
        cfgWrite(8'h00);
        checkOutput("cfg_cs_low", {31'd0, sd_cs_n}, 32'd0);
        spi_req    = 1'b1;
        spi_wrdata = 8'h55;
        dropAfter  = 1;
        applyStimulus(6);
        rst_n   = 1'b0;
        spi_req = 1'b0;
        #1;
        checkOutput("midrst_sd_clk", {31'd0, sd_clk}, 32'd0);
        checkOutput("midrst_sd_cs_n", {31'd0, sd_cs_n}, 32'd1);
        checkOutput("midrst_z_rddata", {24'd0, z_rddata}, 32'hFF);
        checkOutput("midrst_z_busy", {31'd0, z_busy}, 32'd0);
        applyStimulus(3);
        rst_n = 1'b1;
        applyStimulus(20);
        checkOutput("midrst_no_stb", stbCnt, 0);
        zdata = 8'h00;
        z_dwr = 1'b1;
        applyStimulus(25);
        checkOutput("postrst_z_rddata", {24'd0, z_rddata}, 32'h00);
        checkOutput("postrst_pulses", pulses, 8);

        $display("[TB] DMA burst 0x3C, 0xC3");
        spi_req    = 1'b1;
        spi_wrdata = 8'h3C;
        nextWr     = 8'hC3;
        dropAfter  = 2;
        applyStimulus(45);
        checkOutput("burst_stb_count", stbCnt, 2);
        checkOutput("burst_stb_spacing", stbCycle[1] - stbCycle[0], 18);
        checkOutput("burst_first_stb", stbCycle[0], 17);
        checkOutput("burst_data0", {24'd0, stbData[0]}, 32'h3C);
        checkOutput("burst_data1", {24'd0, stbData[1]}, 32'hC3);
        checkOutput("burst_mosi", {16'd0, mosiBits}, 32'h3CC3);

        $display("[TB] Z80 read colliding with DMA request");
        spi_req    = 1'b1;
        spi_wrdata = 8'h5A;
        nextWr     = 8'h5A;
        dropAfter  = 1;
        z_drd      = 1'b1;
        applyStimulus(45);
        checkOutput("coll_stb_count", stbCnt, 1);
        checkOutput("coll_stb_cycle", stbCycle[0], 35);
        checkOutput("coll_stb_data", {24'd0, stbData[0]}, 32'h5A);
        checkOutput("coll_mosi", {16'd0, mosiBits}, 32'hFF5A);
        checkOutput("coll_z_rddata", {24'd0, z_rddata}, 32'h5A);

        $display("[TB] Z80 write pending behind a DMA byte");
        spi_req     = 1'b1;
        spi_wrdata  = 8'h77;
        nextWr      = 8'h88;
        dropAfter   = 2;
        injectCycle = 5;
        injectData  = 8'h11;
        applyStimulus(60);
        checkOutput("pend_stb_count", stbCnt, 2);
        checkOutput("pend_stb0_cycle", stbCycle[0], 17);
        checkOutput("pend_stb1_cycle", stbCycle[1], 53);
        checkOutput("pend_data0", {24'd0, stbData[0]}, 32'h77);
        checkOutput("pend_data1", {24'd0, stbData[1]}, 32'h88);
        checkOutput("pend_mosi", {16'd0, mosiBits}, 32'h7711);
        checkOutput("pend_busy_cycles", busyCnt, 52);

        $display("[TB] bit order config");
        cfgWrite(8'h02);
        checkOutput("lsbf_cfg_cs", {31'd0, sd_cs_n}, 32'd0);
        zdata = 8'h01;
        z_dwr = 1'b1;
        applyStimulus(25);
`ifdef SPI_LSBF_EN
        checkOutput("lsbf_first_bit", {31'd0, mosiBits[7]}, 32'd1);
`else
        checkOutput("lsbf_first_bit", {31'd0, mosiBits[7]}, 32'd0);
`endif
        checkOutput("lsbf_z_rddata", {24'd0, z_rddata}, 32'h01);
        cfgWrite(8'h01);
        checkOutput("msbf_cfg_cs", {31'd0, sd_cs_n}, 32'd1);
        zdata = 8'h01;
        z_dwr = 1'b1;
        applyStimulus(25);
        checkOutput("msbf_first_bit", {31'd0, mosiBits[7]}, 32'd0);
        checkOutput("msbf_z_rddata", {24'd0, z_rddata}, 32'h01);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
